// File: rtl/serial_sequencer.sv
// Bit-level sequencer for the bit-serial datapath: turns one alu_start pulse into
// per-cycle shift enables, zero-fill, carry seed and a one-cycle completion pulse.
module serial_sequencer #(
   parameter int WIDTH = 8,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [2:0]    alu_op,
   input  logic [CW-1:0] shamt,
   output logic          src_shift_en,
   output logic          acc_shift_en,
   output logic          zero_fill,
   output logic          first_bit,
   output logic          carry_seed,
   output logic [CW-1:0] bit_idx,
   output logic          busy,
   output logic          bit_done
);

   // state  | meaning
   // S_IDLE | waiting for start; op/shamt latched on start
   // S_SKIP | SRLI only: discard shamt low source bits, accumulator held
   // S_RUN  | WIDTH cycles, one result bit written per cycle
   // S_DONE | one-cycle bit_done, then back to idle
   typedef enum logic [1:0] {S_IDLE, S_SKIP, S_RUN, S_DONE} state_t;

   localparam logic [2:0]  OP_SUB   = 3'b001;
   localparam logic [2:0]  OP_SLLI  = 3'b101;
   localparam logic [2:0]  OP_SRLI  = 3'b110;
   localparam logic [CW:0] CNT_LAST = (CW+1)'(WIDTH - 1);
   localparam logic [CW:0] CNT_W    = (CW+1)'(WIDTH);

   state_t        state_q, state_d;
   logic [CW:0]   cnt_q, cnt_d;
   logic [2:0]    op_q, op_d;
   logic [CW-1:0] shamt_q, shamt_d;

   logic          src_shift_en_q, src_shift_en_d;
   logic          acc_shift_en_q, acc_shift_en_d;
   logic          zero_fill_q, zero_fill_d;
   logic          first_bit_q, first_bit_d;
   logic          carry_seed_q, carry_seed_d;
   logic [CW-1:0] bit_idx_q, bit_idx_d;
   logic          busy_q, busy_d;
   logic          bit_done_q, bit_done_d;

   logic [CW:0]   shamt_ext_q;
   logic [CW:0]   shamt_ext_d;
   logic          run_d;
   logic          fill_d;

   assign shamt_ext_q = {1'b0, shamt_q};
   assign shamt_ext_d = {1'b0, shamt_d};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      shamt_d = shamt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = alu_op;
               shamt_d = shamt;
               cnt_d   = '0;
               if (alu_op == OP_SRLI && shamt != '0) state_d = S_SKIP;
               else                                  state_d = S_RUN;
            end
         end
         S_SKIP: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == shamt_ext_q - 1'b1) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next-state values and registered, so they line
   // up with the state they describe and never see start/abort combinationally.
   always_comb begin
      run_d  = (state_d == S_RUN);
      fill_d = run_d &&
               ((op_d == OP_SLLI && cnt_d < shamt_ext_d) ||
                (op_d == OP_SRLI && cnt_d >= CNT_W - shamt_ext_d));
      src_shift_en_d = (state_d == S_SKIP) || (run_d && !fill_d);
      acc_shift_en_d = run_d;
      zero_fill_d    = fill_d;
      first_bit_d    = run_d && (cnt_d == '0);
      carry_seed_d   = run_d && (cnt_d == '0) && (op_d == OP_SUB);
      bit_idx_d      = run_d ? cnt_d[CW-1:0] : '0;
      busy_d         = (state_d == S_SKIP) || run_d;
      bit_done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         op_q           <= '0;
         shamt_q        <= '0;
         src_shift_en_q <= 1'b0;
         acc_shift_en_q <= 1'b0;
         zero_fill_q    <= 1'b0;
         first_bit_q    <= 1'b0;
         carry_seed_q   <= 1'b0;
         bit_idx_q      <= '0;
         busy_q         <= 1'b0;
         bit_done_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         op_q           <= op_d;
         shamt_q        <= shamt_d;
         src_shift_en_q <= src_shift_en_d;
         acc_shift_en_q <= acc_shift_en_d;
         zero_fill_q    <= zero_fill_d;
         first_bit_q    <= first_bit_d;
         carry_seed_q   <= carry_seed_d;
         bit_idx_q      <= bit_idx_d;
         busy_q         <= busy_d;
         bit_done_q     <= bit_done_d;
      end
   end

   assign src_shift_en = src_shift_en_q;
   assign acc_shift_en = acc_shift_en_q;
   assign zero_fill    = zero_fill_q;
   assign first_bit    = first_bit_q;
   assign carry_seed   = carry_seed_q;
   assign bit_idx      = bit_idx_q;
   assign busy         = busy_q;
   assign bit_done     = bit_done_q;

endmodule

// File: doc/serial_sequencer.md
Name: serial_sequencer

Overview:
Bit-level sequencer for the bit-serial datapath. It is triggered by the control FSM's alu_start pulse and produces per-cycle shift enables for the operand source registers and the accumulator. It also seeds the ALU carry for SUB, inserts zero fill and source skips for SLLI/SRLI by shamt, and returns a one-cycle bit_done when the word is complete. It sits between the control FSM and the shift registers / serial ALU.

Parameters:
WIDTH, 8, datapath word width in bits (power of 2, >= 4)
CW, 3, counter/shamt width = log2(WIDTH)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle start pulse (FSM alu_start)
abort  input  1  synchronous cancel of an in-flight operation
alu_op  input  3  000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, 101 SLLI, 110 SRLI, 111 treated as ADD
shamt  input  CW  shift amount, sampled with start
src_shift_en  output  1  shift operand source registers one bit (LSB first)
acc_shift_en  output  1  shift ALU result bit into accumulator
zero_fill  output  1  force the ALU result bit to 0 this cycle
first_bit  output  1  high on the first RUN cycle only
carry_seed  output  1  carry-in value for the ALU on first_bit (1 for SUB, else 0)
bit_idx  output  CW  index of the result bit being written (valid in RUN)
busy  output  1  high in SKIP and RUN
bit_done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is synchronous, active-low.
- Reset: state=IDLE. All outputs are 0. Latched op/shamt/counter are cleared. Reset mid-operation terminates with no bit_done.
- Latching: op and shamt are latched only when start=1 in IDLE. start in any other state is ignored, including DONE. Input changes after the latch have no effect.
- States: IDLE, SKIP, RUN, DONE. cnt is a CW+1-bit counter.
- IDLE to SKIP: on start, if op==SRLI and shamt!=0. Clear cnt.
- IDLE to RUN: on start, otherwise. Clear cnt.
- SKIP: src_shift_en=1, acc_shift_en=0. Lasts exactly shamt cycles, then RUN with cnt cleared.
- RUN: exactly WIDTH cycles, cnt 0..WIDTH-1. acc_shift_en=1 every cycle. bit_idx=cnt. first_bit=(cnt==0). carry_seed=(op==SUB)&first_bit.
  - SLLI: for cnt<shamt, zero_fill=1 and src_shift_en=0; otherwise src_shift_en=1.
  - SRLI: for cnt>=WIDTH-shamt, zero_fill=1 and src_shift_en=0; otherwise src_shift_en=1.
  - All other ops: src_shift_en=1, zero_fill=0.
  - shamt=0: no zero fill, no hold, no SKIP.
- RUN to DONE: after the cnt==WIDTH-1 cycle.
- DONE: bit_done=1 for one cycle, busy=0, all enables 0. Then IDLE.
- Latency (start high in cycle 0): bit_done in cycle WIDTH+1, or WIDTH+1+shamt for SRLI.
- Outputs: all outputs are registered or decoded from registered state only. No combinational path from start or abort.
- Abort: abort=1 in SKIP or RUN goes to IDLE on the next edge. No bit_done, outputs 0 from that edge. abort in IDLE/DONE has no effect. Simultaneous start+abort in IDLE: start wins (abort is ignored in IDLE).
- Total source shifts per op: WIDTH (logic/arith), WIDTH-shamt (SLLI), WIDTH (SRLI: shamt in SKIP plus WIDTH-shamt in RUN).

Test Plan:
- Reset, then ADD start: first_bit and carry_seed=0 at cycle 1. acc_shift_en and src_shift_en high cycles 1-8. bit_idx 0..7. bit_done only at cycle 9. busy high cycles 1-8.
- SUB start: carry_seed=1 with first_bit in cycle 1 only. With A=0x05, B=0x03 on an attached ALU model, accumulator=0x02 at bit_done.
- SLLI shamt=3, source 0x1B: zero_fill and src hold for bit_idx 0-2. Accumulator=0xD8. bit_done at cycle 9.
- SRLI shamt=2, source 0xB4: SKIP cycles 1-2 with acc_shift_en=0. zero_fill for bit_idx 6-7. Accumulator=0x2D. bit_done at cycle 11.
- abort in the 4th RUN cycle: all enables 0 next cycle, no bit_done. A new start 2 cycles later runs a full 8-bit op normally.
- start pulses during RUN and DONE are ignored (single bit_done). rst_n=0 mid-RUN gives all outputs 0 next edge. SRLI shamt=0 skips SKIP, bit_done at cycle 9.
